// File: rtl/seq_alu.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module      : seq_alu
//  Description : Sequential ALU. Single-cycle add/sub/logic/shift/compare;
//                iterative shift-add unsigned multiply taking W steps.
//  Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module seq_alu #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2:0]     s,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] out,
    output logic           busy,
    output logic           done,
    output logic           zero
);

    localparam logic [2:0] c_op_add = 3'b000;
    localparam logic [2:0] c_op_sub = 3'b001;
    localparam logic [2:0] c_op_mul = 3'b010;
    localparam logic [2:0] c_op_and = 3'b011;
    localparam logic [2:0] c_op_or  = 3'b100;
    localparam logic [2:0] c_op_xor = 3'b101;
    localparam logic [2:0] c_op_shl = 3'b110;
    localparam logic [2:0] c_op_cmp = 3'b111;

    // Step counter counts 0..W-1; the last step is where the product lands.
    localparam int                 c_cnt_w = $clog2(W + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(W - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [2*W-1:0]     r_acc;
    logic [2*W-1:0]     r_mcand;
    logic [W-1:0]       r_mplier;
    logic [c_cnt_w-1:0] r_cnt;

    logic               w_accept;
    logic               w_last;
    logic [2*W-1:0]     w_ext_a;
    logic [2*W-1:0]     w_ext_b;
    logic [2*W-1:0]     w_res;
    logic [2*W-1:0]     w_acc_nxt;

    // A start is only honoured when no multiply is running.
    assign w_accept  = start && (r_state == IDLE);
    assign w_last    = (r_cnt == c_last);
    assign w_ext_a   = {{W{1'b0}}, a};
    assign w_ext_b   = {{W{1'b0}}, b};
    assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign busy      = (r_state == MUL);

    // Single-cycle result for every opcode except multiply.
    always_comb begin
        w_res = '0;
        case (s)
            c_op_add: w_res = w_ext_a + w_ext_b;
            c_op_sub: w_res = w_ext_a - w_ext_b;
            c_op_and: w_res = w_ext_a & w_ext_b;
            c_op_or:  w_res = w_ext_a | w_ext_b;
            c_op_xor: w_res = w_ext_a ^ w_ext_b;
            // Shift distances of 2W or more push every bit out, giving 0.
            c_op_shl: w_res = w_ext_a << b;
            c_op_cmp: w_res = {{(2*W-3){1'b0}}, (a < b), (a == b), (a > b)};
            default:  w_res = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: enter MUL on an accepted multiply, leave after W steps.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept && (s == c_op_mul)) w_state_nxt = MUL;
            MUL:     if (w_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, shift-add steps and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out      <= '0;
            zero     <= 1'b1;
            done     <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else begin
            done <= 1'b0;
            if (r_state == IDLE) begin
                if (w_accept) begin
                    if (s == c_op_mul) begin
                        r_acc    <= '0;
                        r_mcand  <= w_ext_a;
                        r_mplier <= b;
                        r_cnt    <= '0;
                    end else begin
                        out  <= w_res;
                        zero <= (w_res == '0);
                        done <= 1'b1;
                    end
                end
            end else begin
                // One multiplier bit per edge, LSB first.
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + c_one;
                if (w_last) begin
                    out   <= w_acc_nxt;
                    zero  <= (w_acc_nxt == '0);
                    done  <= 1'b1;
                    r_cnt <= '0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter W SHALL be declared with default 4; it is the operand width in bits, and any W >= 2 is legal.
REQ-002 Port clk SHALL be an input, 1 bit wide: the single clock, rising-edge active.
REQ-003 Port rst SHALL be an input, 1 bit wide: reset, asynchronous and active-high.
REQ-004 Port start SHALL be an input, 1 bit wide: operation request, sampled on the rising clk edge.
REQ-005 Port s SHALL be an input, 3 bits wide: the opcode.
REQ-006 Ports a and b SHALL be inputs, W bits wide each: unsigned operands.
REQ-007 Port out SHALL be an output, 2W bits wide: the registered result.
REQ-008 Port busy SHALL be an output, 1 bit wide: high while a multiply is in progress.
REQ-009 Port done SHALL be an output, 1 bit wide: a one-cycle pulse marking out as updated.
REQ-010 Port zero SHALL be an output, 1 bit wide: registered, high when the latched out equals 0.

Function
REQ-011 The block SHALL capture s, a and b on the edge where start=1 and busy=0; later input changes SHALL not affect that operation.
REQ-012 start while busy=1 SHALL be ignored: no capture and no queueing.
REQ-013 The state machine SHALL have states IDLE and MUL; IDLE SHALL go to MUL on an accepted start with s=010, and MUL SHALL return to IDLE after W step edges.
REQ-014 Opcodes SHALL be: 000 add (a+b, zero-extended, carry in bit W); 001 sub ((a-b) mod 2^(2W)); 010 mul (unsigned a*b); 011 and; 100 or; 101 xor (logic ops zero-extended); 110 shl ((a << b) mod 2^(2W), b >= 2W gives 0); 111 cmp (out[2]=a<b, out[1]=a==b, out[0]=a>b, upper bits 0).
REQ-015 Non-multiply ops SHALL update out, zero and done=1 on the capture edge itself (1-cycle latency); busy SHALL stay 0.
REQ-016 Multiply SHALL be an iterative shift-add: busy SHALL go to 1 at the capture edge, and one multiplier bit SHALL be consumed per edge over the following W edges.
REQ-017 On the W-th edge after capture, out SHALL take the full 2W-bit product, done SHALL pulse 1, and busy SHALL return to 0; start SHALL be accepted on the next edge.
REQ-018 out SHALL hold its last value during a multiply and between operations; done SHALL be 1 for exactly one cycle per operation.
REQ-019 The product SHALL never overflow, since the maximum (2^W-1)^2 fits in 2W bits.
REQ-020 Back-to-back non-multiply starts SHALL each complete, giving one done pulse per cycle.

Reset
REQ-021 rst=1 SHALL immediately, without waiting for clk, force: out=0, zero=1, done=0, busy=0, state IDLE, internal accumulator and counter cleared.
REQ-022 rst asserted mid-multiply SHALL abort the operation with no done pulse; after release the block SHALL accept a new start.
REQ-023 start SHALL be ignored while rst=1.

Verification (W=4)
REQ-024 a=2, b=7 through s=000, 001, 011, 100, 101, 110, 111 -> out=09, FB, 02, 07, 05, 00, 04 (hex), each a 1-cycle done pulse with busy=0.
REQ-025 a=2, b=7, s=010 -> busy high for 4 edges, then out=0E, done pulse, busy=0; the previous out is held until then.
REQ-026 a=F, b=F, s=010 -> out=E1; then a=0, s=011 -> out=00, zero=1.
REQ-027 A start during a multiply with s=000, a=1, b=1 -> ignored; only the product appears, with one done pulse.
REQ-028 rst pulsed 2 cycles into a multiply -> outputs go immediately to their reset values, with no done pulse; a subsequent add of 3+4 -> out=07.
REQ-029 Parameter W=8 with a=FF, b=FF, s=010 -> out=FE01 after 8 edges; s=000 -> out=01FE.
